// File: rtl/i2c_pkg.sv
// Shared types and constants for the system-clocked I2C register target.
// Optional SCL/SDA majority filter is enabled with I2C_GLITCH_FILTER_EN.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;
   localparam logic [I2C_BYTE_W-1:0] I2C_OOR_READ = 8'hFF;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WR,
      ST_WR_ACK,
      ST_RD,
      ST_RD_MACK,
      ST_WAIT_STOP
   } i2c_state_t;

   // 2-of-3 vote used by the glitch filter
   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Pad conditioner for one I2C line: synchroniser, optional filter, edges.
// Defining I2C_GLITCH_FILTER_EN adds a 3-sample majority stage.
module i2c_line_cond
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   clean;

`ifdef I2C_GLITCH_FILTER_EN
   logic [2:0] win_q, win_d;
   logic       filt_q, filt_d;

   // sample window and majority vote; single-sample spikes never win
   always_comb begin
      win_d  = {win_q[1:0], sync_q[SYNC_STAGES-1]};
      filt_d = maj3(win_q);
   end

   // filter state, idle bus reads high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q  <= 3'b111;
         filt_q <= 1'b1;
      end else begin
         win_q  <= win_d;
         filt_q <= filt_d;
      end
   end

   assign clean = filt_q;
`else
   assign clean = sync_q[SYNC_STAGES-1];
`endif

   // shift chain and previous-level capture
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
      prev_d = clean;
   end

   // synchroniser and edge-detect flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = clean;
   assign rise  = clean & ~prev_q;
   assign fall  = ~clean & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// Oversampled I2C target exposing a pointer-addressed byte register bank.
// Define I2C_GLITCH_FILTER_EN to add majority filtering on SCL/SDA.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter int NUM_REGS    = 8,
   parameter int PTR_W       = $clog2(NUM_REGS),
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [I2C_ADDR_W-1:0]   my_addr,
   input  logic                    scl_in,
   input  logic                    sda_in,
   output logic                    sda_oe,
   input  logic [8*NUM_REGS-1:0]   rd_regs,
   output logic [8*NUM_REGS-1:0]   wr_regs,
   output logic                    wr_strobe,
   output logic [PTR_W-1:0]        wr_idx,
   output logic                    busy
);

   i2c_state_t state_q, state_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [I2C_ADDR_W-1:0]     shreg_q, shreg_d;
   logic [I2C_BYTE_W-1:0]     ptr_q, ptr_d;
   logic                      sda_oe_q, sda_oe_d;
   logic [8*NUM_REGS-1:0]     wr_regs_q, wr_regs_d;
   logic                      wr_strobe_q, wr_strobe_d;
   logic [PTR_W-1:0]          wr_idx_q, wr_idx_d;
   logic                      busy_q, busy_d;

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;
   logic ptr_ok, addr_hit;
   logic [I2C_BYTE_W-1:0] byte_in, rd_byte, ptr_nxt;

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
      .clk    (clk),
      .reset  (reset),
      .pad_in (scl_in),
      .level  (scl_lvl),
      .rise   (scl_rise),
      .fall   (scl_fall)
   );

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
      .clk    (clk),
      .reset  (reset),
      .pad_in (sda_in),
      .level  (sda_lvl),
      .rise   (sda_rise),
      .fall   (sda_fall)
   );

   assign start    = sda_fall & scl_lvl;
   assign stop     = sda_rise & scl_lvl;
   assign byte_in  = {shreg_q, sda_lvl};
   assign addr_hit = (byte_in[7:1] == my_addr);
   assign ptr_ok   = ({1'b0, ptr_q} < 9'(NUM_REGS));
   assign ptr_nxt  = (ptr_q == 8'(NUM_REGS-1)) ? 8'h00 : ptr_q + 8'h01;

   // read mux; pointers past the bank return the fill pattern
   always_comb begin
      rd_byte = I2C_OOR_READ;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ptr_q == 8'(i)) rd_byte = rd_regs[8*i +: 8];
      end
   end

   // protocol FSM: bits in on SCL rise, SDA drive changes on SCL fall
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      wr_regs_d   = wr_regs_q;
      wr_strobe_d = 1'b0;
      wr_idx_d    = wr_idx_q;
      busy_d      = busy_q;

      if (!en || stop) begin
         state_d  = ST_IDLE;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start) begin
         state_d  = ST_ADDR;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shreg_d = byte_in[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     if (addr_hit) begin
                        state_d = ST_ADDR_ACK;
                     end else begin
                        state_d = ST_WAIT_STOP;
                        busy_d  = 1'b0;
                     end
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                  end else if (shreg_q[0]) begin
                     state_d  = ST_RD;
                     cnt_d    = 4'd0;
                     sda_oe_d = ~rd_byte[7];
                  end else begin
                     state_d  = ST_PTR;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            ST_PTR: begin
               if (scl_rise) begin
                  shreg_d = byte_in[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d   = 4'd0;
                     ptr_d   = byte_in;
                     state_d = ST_PTR_ACK;
                  end
               end
            end
            ST_PTR_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WR;
                  end
               end
            end
            ST_WR: begin
               if (scl_rise) begin
                  shreg_d = byte_in[6:0];
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d   = 4'd0;
                     state_d = ST_WR_ACK;
                     ptr_d   = ptr_nxt;
                     if (ptr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                           if (ptr_q == 8'(i)) wr_regs_d[8*i +: 8] = byte_in;
                        end
                        wr_strobe_d = 1'b1;
                        wr_idx_d    = ptr_q[PTR_W-1:0];
                     end
                  end
               end
            end
            ST_RD: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     state_d  = ST_RD_MACK;
                     cnt_d    = 4'd0;
                     sda_oe_d = 1'b0;
                     ptr_d    = ptr_nxt;
                  end else begin
                     sda_oe_d = ~rd_byte[3'd7 - cnt_q[2:0]];
                  end
               end
            end
            ST_RD_MACK: begin
               if (scl_rise) begin
                  if (!sda_lvl) begin
                     cnt_d = 4'd1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                     busy_d  = 1'b0;
                  end
               end else if (scl_fall && cnt_q == 4'd1) begin
                  state_d  = ST_RD;
                  cnt_d    = 4'd0;
                  sda_oe_d = ~rd_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         shreg_q     <= '0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         wr_regs_q   <= '0;
         wr_strobe_q <= 1'b0;
         wr_idx_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         wr_regs_q   <= wr_regs_d;
         wr_strobe_q <= wr_strobe_d;
         wr_idx_q    <= wr_idx_d;
         busy_q      <= busy_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign wr_regs   = wr_regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_idx    = wr_idx_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged master against a register model.
// Spike rejection is exercised when I2C_GLITCH_FILTER_EN is defined.
module tb_i2c_target_regs;

   localparam int N  = 8;
   localparam int PW = $clog2(N);
   localparam int Q  = 5;

   logic           clk = 1'b0;
   logic           reset, en;
   logic [6:0]     my_addr;
   logic           scl_m, sda_m;
   logic           scl_in, sda_in, sda_oe;
   logic [8*N-1:0] rd_regs, wr_regs;
   logic           wr_strobe, busy;
   logic [PW-1:0]  wr_idx;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target_regs #(.NUM_REGS(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .my_addr   (my_addr),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .rd_regs   (rd_regs),
      .wr_regs   (wr_regs),
      .wr_strobe (wr_strobe),
      .wr_idx    (wr_idx),
      .busy      (busy)
   );

   int          vectors, miscompares;
   int unsigned oe_hits;
   logic [7:0]  rd_arr[N];
   logic [7:0]  mregs[N];
   logic [7:0]  mptr;
   logic [7:0]  wdata[$];
   logic [7:0]  exp_strobe[$];
   logic [7:0]  strobe_seen[$];

   always_comb begin
      rd_regs = '0;
      for (int i = 0; i < N; i++) rd_regs[8*i +: 8] = rd_arr[i];
   end

   always @(negedge clk) begin
      if (wr_strobe) strobe_seen.push_back(8'(wr_idx));
      if (sda_oe) oe_hits++;
   end

   function automatic logic [7:0] ptr_next(input logic [7:0] p);
      return (int'(p) == N-1) ? 8'h00 : 8'(int'(p) + 1);
   endfunction

   function automatic logic [8*N-1:0] mregs_packed();
      logic [8*N-1:0] v;
      for (int i = 0; i < N; i++) v[8*i +: 8] = mregs[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; q();
      scl_m = 1'b1; q();
      sda_m = 1'b1; q();
   endtask

   task automatic put_bit(input logic b, input bit spike);
      sda_m = b; q();
      scl_m = 1'b1; q();
      if (spike) begin
         scl_m = 1'b0;
         @(negedge clk);
         scl_m = 1'b1;
      end
      q();
      scl_m = 1'b0; q();
   endtask

   task automatic put_byte(input logic [7:0] b, input int spike_at, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(b[i], i == spike_at);
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      ack = ~sda_in; q();
      scl_m = 1'b0; q();
   endtask

   task automatic get_byte(input logic nack, output logic [7:0] v);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         q();
         scl_m = 1'b1; q();
         v[i] = sda_in; q();
         scl_m = 1'b0;
      end
      q();
      put_bit(nack, 1'b0);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int spike_at);
      logic ack, hit;
      hit = (a == my_addr);
      bus_start();
      put_byte({a, 1'b0}, -1, ack);
      chk("w_addr_ack", 64'(ack), 64'(hit));
      put_byte(p, -1, ack);
      chk("w_ptr_ack", 64'(ack), 64'(hit));
      if (hit) mptr = p;
      for (int k = 0; k < wdata.size(); k++) begin
         put_byte(wdata[k], (k == 0) ? spike_at : -1, ack);
         chk("w_data_ack", 64'(ack), 64'(hit));
         if (hit) begin
            if (int'(mptr) < N) begin
               mregs[int'(mptr)] = wdata[k];
               exp_strobe.push_back(mptr);
            end
            mptr = ptr_next(mptr);
         end
      end
      bus_stop(); q();
      chk("w_busy_end", 64'(busy), 64'(0));
      chk("w_strobe_cnt", 64'(strobe_seen.size()), 64'(exp_strobe.size()));
      for (int k = 0; k < exp_strobe.size(); k++) begin
         if (k < strobe_seen.size())
            chk("w_strobe_idx", 64'(strobe_seen[k]), 64'(exp_strobe[k]));
      end
      chk("w_regs", 64'(wr_regs), 64'(mregs_packed()));
      strobe_seen.delete();
      exp_strobe.delete();
   endtask

   task automatic do_read(input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] v, e;
      bus_start();
      put_byte({my_addr, 1'b0}, -1, ack);
      chk("r_addr_ack", 64'(ack), 64'(1));
      put_byte(p, -1, ack);
      chk("r_ptr_ack", 64'(ack), 64'(1));
      mptr = p;
      bus_rstart();
      put_byte({my_addr, 1'b1}, -1, ack);
      chk("r_raddr_ack", 64'(ack), 64'(1));
      chk("r_busy", 64'(busy), 64'(1));
      for (int k = 0; k < n; k++) begin
         get_byte(k == n-1, v);
         e = (int'(mptr) < N) ? rd_arr[int'(mptr)] : 8'hFF;
         chk("r_data", 64'(v), 64'(e));
         mptr = ptr_next(mptr);
      end
      q();
      chk("r_busy_nack", 64'(busy), 64'(0));
      bus_stop(); q();
      chk("r_no_strobe", 64'(strobe_seen.size()), 64'(0));
      strobe_seen.delete();
   endtask

   initial begin
      logic ack;
      vectors = 0; miscompares = 0; oe_hits = 0;
      reset = 1'b0; en = 1'b1; my_addr = 7'h2A;
      scl_m = 1'b1; sda_m = 1'b1; mptr = 8'h00;
      for (int i = 0; i < N; i++) begin
         rd_arr[i] = 8'(8'h10 + i);
         mregs[i]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", 64'(sda_oe), 64'(0));
      chk("rst_wr_regs", 64'(wr_regs), 64'(0));
      chk("rst_strobe", 64'(wr_strobe), 64'(0));
      chk("rst_wr_idx", 64'(wr_idx), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      reset = 1'b1;
      repeat (5) @(negedge clk);

      wdata = {8'hA5, 8'h5A};
      do_write(7'h2A, 8'h03, -1);
      chk("t1_reg3", 64'(wr_regs[31:24]), 64'(8'hA5));
      chk("t1_reg4", 64'(wr_regs[39:32]), 64'(8'h5A));

      do_read(8'h01, 3);
      do_read(8'h07, 2);
      do_read(8'hFF, 2);

      oe_hits = 0;
      wdata = {8'h11, 8'h22};
      do_write(7'h2B, 8'h00, -1);
      chk("na_oe_never", 64'(oe_hits), 64'(0));

      bus_start();
      for (int i = 7; i >= 0; i--) put_bit(i == 0 ? 1'b0 : my_addr[i-1], 1'b0);
      sda_m = 1'b1; q();
      chk("en_ack_oe", 64'(sda_oe), 64'(1));
      chk("en_busy", 64'(busy), 64'(1));
      en = 1'b0;
      @(negedge clk);
      chk("en_oe_off", 64'(sda_oe), 64'(0));
      chk("en_busy_off", 64'(busy), 64'(0));
      en = 1'b1;
      scl_m = 1'b1; q();
      scl_m = 1'b0; q();
      bus_stop(); q();

      rd_arr[2] = 8'h00;
      bus_start();
      put_byte({my_addr, 1'b0}, -1, ack);
      put_byte(8'h02, -1, ack);
      bus_rstart();
      put_byte({my_addr, 1'b1}, -1, ack);
      chk("mr_oe_driving", 64'(sda_oe), 64'(1));
      reset = 1'b0;
      #1;
      chk("mr_sda_oe", 64'(sda_oe), 64'(0));
      chk("mr_busy", 64'(busy), 64'(0));
      chk("mr_wr_regs", 64'(wr_regs), 64'(0));
      chk("mr_wr_idx", 64'(wr_idx), 64'(0));
      for (int i = 0; i < N; i++) mregs[i] = 8'h00;
      mptr = 8'h00;
      @(negedge clk);
      scl_m = 1'b1; sda_m = 1'b1; q();
      reset = 1'b1; q();
      strobe_seen.delete();

      for (int t = 0; t < 14; t++) begin
         int n;
         logic [7:0] p;
         p = 8'($urandom_range(0, N+3));
         n = int'($urandom_range(1, 3));
         if ($urandom_range(0, 1) == 0) begin
            wdata.delete();
            for (int k = 0; k < n; k++) wdata.push_back(8'($urandom));
            do_write(my_addr, p, -1);
         end else begin
            for (int i = 0; i < N; i++) rd_arr[i] = 8'($urandom);
            do_read(p, n);
         end
      end

`ifdef I2C_GLITCH_FILTER_EN
      wdata = {8'hC3};
      do_write(my_addr, 8'h05, 3);
      chk("gf_reg5", 64'(wr_regs[47:40]), 64'(8'hC3));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Parametrised, system-clocked I2C target for the RFID sensor interface. SCL/SDA are oversampled on `clk`, not used as clocks. The block exposes an addressed bank of byte registers: the master writes a register pointer and then data bytes, or reads measurement bytes, with pointer auto-increment. It replaces the SCL-clocked single-measurement slave and adds repeated START, multi-byte bursts and a writable register bank.

## Interface
- `NUM_REGS`, 8: number of byte registers, 2..256.
- `PTR_W`, `$clog2(NUM_REGS)`: pointer index width (derived; do not override).
- `SYNC_STAGES`, 2: synchroniser flops on SCL/SDA, ≥2.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; low forces IDLE and releases SDA.
- `my_addr`  in  7  target address.
- `scl_in`  in  1  SCL pad input.
- `sda_in`  in  1  SDA pad input.
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `rd_regs`  in  8*NUM_REGS  read bank; byte i at [8i+7:8i].
- `wr_regs`  out  8*NUM_REGS  write bank, held in flops.
- `wr_strobe`  out  1  one-cycle pulse per committed write byte.
- `wr_idx`  out  PTR_W  index written on `wr_strobe`.
- `busy`  out  1  high from addressed-match ACK until STOP/NACK/IDLE.

## Operation
- Reset values: `sda_oe`=0, `wr_regs`=0, `wr_strobe`=0, `wr_idx`=0, `busy`=0, pointer=0, state IDLE.
- Conditioned SCL/SDA give `scl_rise`, `scl_fall`, `start` (SDA fall while SCL high), `stop` (SDA rise while SCL high).
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_MACK, WAIT_STOP.
- `start` in any state → ADDR, bit count 0 (covers repeated START). `stop` in any state → IDLE.
- ADDR: shift 8 bits MSB first on `scl_rise`. Match on [7:1] → ADDR_ACK; mismatch → WAIT_STOP.
- After ADDR_ACK: R/W=0 → PTR; R/W=1 → RD.
- PTR: byte loads the pointer, ACKed.
- WR: each byte is ACKed. If pointer < NUM_REGS: write `wr_regs[ptr]`, pulse `wr_strobe`, set `wr_idx`.
- RD: drive `rd_regs[ptr]` MSB first; out-of-range pointer returns 8'hFF. RD_MACK samples the master bit: ACK → next byte; NACK → WAIT_STOP.
- Pointer increments after every data byte, read or write. Wraps NUM_REGS-1 → 0. Out-of-range values do not wrap; they increment mod 256.
- Driving in RD: SDA=0 → `sda_oe`=1, SDA=1 → `sda_oe`=0. ACK: `sda_oe`=1 for the ninth SCL period.
- `en` low: IDLE, `sda_oe`=0 next cycle. `wr_regs` retained.

## Timing
- Edge/condition detect latency: SYNC_STAGES+1 `clk` after the pad transition (+3 with filter).
- `sda_oe` changes exactly 1 `clk` after detected `scl_fall`, never on `scl_rise`.
- Bits sampled on detected `scl_rise`.
- `wr_strobe` asserted the cycle after the eighth data bit is sampled; `wr_regs` updated the same cycle.
- ACK release on the `scl_fall` ending the ninth bit.
- Required: f_clk ≥ 16 × f_SCL.
- Async reset mid-transfer: immediate release of SDA, all outputs to reset values.

## Configuration
- `I2C_GLITCH_FILTER_EN` defined: 3-sample majority filter after the synchronisers on both lines; spikes ≤1 `clk` rejected; +3 cycles latency.
- Undefined: synchronisers only; no filtering.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_state_t`;
  - `I2C_ADDR_W`=7, `I2C_BYTE_W`=8;
  - `I2C_OOR_READ`=8'hFF.
- Sub-module `i2c_line_cond`, instanced per line:
  - synchroniser, optional filter, edge detect;
  - start/stop derived in the top.

## Test plan
- Write my_addr=7'h2A, ptr=8'h03, data 8'hA5,8'h5A, STOP → ACKs on all; `wr_regs` bytes 3,4 = A5,5A; two `wr_strobe` with `wr_idx` 3,4.
- Write ptr=8'h01, repeated START, read 3 bytes (ACK,ACK,NACK), rd_regs[i]=8'h10+i → SDA bytes 11,12,13; `busy` low after NACK.
- NUM_REGS=8, ptr=8'h07, read 2 bytes → 8'h17 then 8'h10 (wrap).
- Address 7'h2B when my_addr=7'h2A → no ACK, `sda_oe` never 1, `wr_strobe` never pulses.
- Assert `reset` low mid-read with `sda_oe`=1 → `sda_oe`=0 immediately, `wr_regs`=0, `busy`=0.
- With `I2C_GLITCH_FILTER_EN`, inject 1-clk SCL-low spike during data → no extra bit shifted, byte intact.
